// File: rtl/vga_pic_win.sv
`default_nettype none
// ============================================================================
// Module   : vga_pic_win
// Purpose  : Packs serial bytes into a picture buffer and overlays it at a
//            movable window origin, with an optional border, on a background.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pic_win #(
    parameter int              H_VALID  = 1024,
    parameter int              V_VALID  = 768,
    parameter int              PIC_W    = 200,
    parameter int              PIC_H    = 200,
    parameter int              DATA_W   = 24,
    parameter int              ADDR_W   = 16,
    parameter int              BORDER_W = 2,
    parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        pi_data,
    input  logic              pi_flag,
    input  logic [11:0]       win_x,
    input  logic [11:0]       win_y,
    input  logic              border_en,
    input  logic [DATA_W-1:0] border_color,
    input  logic [11:0]       pix_x,
    input  logic [11:0]       pix_y,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_done,
    output logic              pic_valid
);

    localparam int                c_NB        = DATA_W / 8;
    localparam int                c_CNT_W     = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int                c_DEPTH     = PIC_W * PIC_H;
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(c_NB - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_DEPTH - 1);
    localparam logic [11:0]       c_X_MAX     = 12'(H_VALID - PIC_W);
    localparam logic [11:0]       c_Y_MAX     = 12'(V_VALID - PIC_H);
    localparam logic [11:0]       c_H_VALID   = 12'(H_VALID);
    localparam logic [11:0]       c_V_VALID   = 12'(V_VALID);
    localparam logic [12:0]       c_PIC_W13   = 13'(PIC_W);
    localparam logic [12:0]       c_PIC_H13   = 13'(PIC_H);
    localparam logic [12:0]       c_BORDER13  = 13'(BORDER_W);

    logic [c_CNT_W-1:0] r_byte_cnt;
    logic [DATA_W-1:0]  r_pack;
    logic [DATA_W-1:0]  w_pack_next;
    logic [DATA_W-1:0]  r_wr_word;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_frame_done;
    logic               r_pic_valid;

    // First byte ends up as the MSB after NB shifts.
    assign w_pack_next = DATA_W'({r_pack, pi_data});

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_byte_cnt <= '0;
            r_pack     <= '0;
            r_wr_word  <= '0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (pi_flag) begin
                r_pack <= w_pack_next;
                if (r_byte_cnt == c_LAST_BYTE) begin
                    r_byte_cnt <= '0;
                    r_wr_en    <= 1'b1;
                    r_wr_word  <= w_pack_next;
                end else begin
                    r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_addr    <= '0;
            r_frame_done <= 1'b0;
            r_pic_valid  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_wr_en) begin
                if (r_wr_addr == c_LAST_ADDR) begin
                    r_wr_addr    <= '0;
                    r_frame_done <= 1'b1;
                    r_pic_valid  <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_W'(1);
                end
            end
        end
    end

    logic        w_origin;
    logic [11:0] w_wx_clamp;
    logic [11:0] w_wy_clamp;
    logic [11:0] r_wx;
    logic [11:0] r_wy;
    logic [11:0] w_wx;
    logic [11:0] w_wy;

    assign w_origin   = (pix_x == 12'd0) && (pix_y == 12'd0);
    assign w_wx_clamp = (win_x > c_X_MAX) ? c_X_MAX : win_x;
    assign w_wy_clamp = (win_y > c_Y_MAX) ? c_Y_MAX : win_y;
    // The freshly latched origin already applies to the (0,0) pixel itself.
    assign w_wx       = w_origin ? w_wx_clamp : r_wx;
    assign w_wy       = w_origin ? w_wy_clamp : r_wy;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wx <= '0;
            r_wy <= '0;
        end else if (w_origin) begin
            r_wx <= w_wx_clamp;
            r_wy <= w_wy_clamp;
        end
    end

    logic [12:0] w_x13, w_y13, w_wx13, w_wy13;
    logic [12:0] w_dx_l, w_dx_r, w_dy_t, w_dy_b;
    logic        w_in_win;
    logic        w_border;
    logic        w_active;

    assign w_x13    = {1'b0, pix_x};
    assign w_y13    = {1'b0, pix_y};
    assign w_wx13   = {1'b0, w_wx};
    assign w_wy13   = {1'b0, w_wy};
    assign w_in_win = (w_x13 >= w_wx13) && (w_x13 < w_wx13 + c_PIC_W13) &&
                      (w_y13 >= w_wy13) && (w_y13 < w_wy13 + c_PIC_H13);
    // Distances to each window edge; only meaningful while inside the window.
    assign w_dx_l   = w_x13 - w_wx13;
    assign w_dx_r   = w_wx13 + c_PIC_W13 - 13'd1 - w_x13;
    assign w_dy_t   = w_y13 - w_wy13;
    assign w_dy_b   = w_wy13 + c_PIC_H13 - 13'd1 - w_y13;
    assign w_border = w_in_win && ((w_dx_l < c_BORDER13) || (w_dx_r < c_BORDER13) ||
                                   (w_dy_t < c_BORDER13) || (w_dy_b < c_BORDER13));
    assign w_active = (pix_x < c_H_VALID) && (pix_y < c_V_VALID);

    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_rd_addr = w_origin ? '0 : r_rd_addr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_addr <= '0;
        end else begin
            r_rd_addr <= w_rd_addr + ADDR_W'(w_in_win);
        end
    end

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Read-first: the non-blocking write is not visible to a same-edge read.
    always_ff @(posedge sys_clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_word;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    logic              r_show_s1;
    logic              r_border_s1;
    logic [DATA_W-1:0] r_pix_data;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_show_s1   <= 1'b0;
            r_border_s1 <= 1'b0;
            r_pix_data  <= '0;
        end else begin
            r_show_s1   <= w_in_win && w_active;
            r_border_s1 <= w_border;
            if (!r_show_s1) begin
                r_pix_data <= BG_COLOR;
            end else if (border_en && r_border_s1) begin
                r_pix_data <= border_color;
            end else if (!r_pic_valid) begin
                r_pix_data <= BG_COLOR;
            end else begin
                r_pix_data <= r_rd_data;
            end
        end
    end

    assign pix_data   = r_pix_data;
    assign frame_done = r_frame_done;
    assign pic_valid  = r_pic_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_pic_win.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pic_win
// Purpose  : Self-checking bench for vga_pic_win on a reduced-size raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pic_win;

    localparam int          c_H      = 64;
    localparam int          c_V      = 48;
    localparam int          c_W      = 16;
    localparam int          c_HT     = 12;
    localparam int          c_BW     = 2;
    localparam int          c_DEPTH  = c_W * c_HT;
    localparam logic [23:0] c_BG     = 24'h123456;
    localparam int          c_LINE   = c_H + 4;
    localparam int          c_FRAME  = c_LINE * (c_V + 2);

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic [7:0]  pi_data      = 8'h00;
    logic        pi_flag      = 1'b0;
    logic [11:0] win_x        = 12'd0;
    logic [11:0] win_y        = 12'd0;
    logic        border_en    = 1'b0;
    logic [23:0] border_color = 24'h000000;
    logic [11:0] pix_x        = 12'(c_H + 10);
    logic [11:0] pix_y        = 12'(c_V + 2);
    logic [23:0] pix_data;
    logic        frame_done;
    logic        pic_valid;

    logic [23:0] pic [c_DEPTH];
    bit          model_valid;
    int          checks;
    int          errors;
    int          fd_count;

    always #5 clk = ~clk;

    vga_pic_win #(
        .H_VALID(c_H), .V_VALID(c_V), .PIC_W(c_W), .PIC_H(c_HT),
        .DATA_W(24), .ADDR_W(8), .BORDER_W(c_BW), .BG_COLOR(c_BG)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .pi_data(pi_data), .pi_flag(pi_flag),
        .win_x(win_x), .win_y(win_y), .border_en(border_en),
        .border_color(border_color), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .frame_done(frame_done), .pic_valid(pic_valid)
    );

    always @(negedge clk) if (frame_done) fd_count++;

    // Picture-level view: what colour belongs at (x,y) for a given origin.
    function automatic logic [23:0] exp_pix(int x, int y, int wx, int wy);
        bit in_w, brd;
        if (x >= c_H || y >= c_V) return c_BG;
        in_w = (x >= wx) && (x < wx + c_W) && (y >= wy) && (y < wy + c_HT);
        if (!in_w) return c_BG;
        brd = (x - wx < c_BW) || (wx + c_W - 1 - x < c_BW) ||
              (y - wy < c_BW) || (wy + c_HT - 1 - y < c_BW);
        if (border_en && brd) return border_color;
        if (!model_valid) return c_BG;
        return pic[(y - wy) * c_W + (x - wx)];
    endfunction

    task automatic scan_frame(input int req_x, input int req_y, input bit do_mid, input int mid_x);
        int          wx, wy, x, y;
        logic [23:0] qe[$];
        int          qx[$], qy[$];
        logic [23:0] e;
        int          ex, ey;
        @(negedge clk);
        win_x = 12'(req_x);
        win_y = 12'(req_y);
        wx = (req_x > c_H - c_W)  ? c_H - c_W  : req_x;
        wy = (req_y > c_V - c_HT) ? c_V - c_HT : req_y;
        for (int i = 0; i < c_FRAME + 2; i++) begin
            @(negedge clk);
            if (qe.size() == 2 || (i >= c_FRAME && qe.size() > 0)) begin
                e  = qe.pop_front();
                ex = qx.pop_front();
                ey = qy.pop_front();
                checks++;
                if (pix_data !== e) begin
                    errors++;
                    $display("FAIL pix(%0d,%0d) origin(%0d,%0d) got %h exp %h",
                             ex, ey, wx, wy, pix_data, e);
                end
            end
            if (i < c_FRAME) begin
                x = i % c_LINE;
                y = i / c_LINE;
                pix_x = 12'(x);
                pix_y = 12'(y);
                qe.push_back(exp_pix(x, y, wx, wy));
                qx.push_back(x);
                qy.push_back(y);
                if (do_mid && y == c_V / 2 && x == 0) win_x = 12'(mid_x);
            end else begin
                pix_x = 12'(c_H + 10);
                pix_y = 12'(c_V + 2);
            end
        end
    endtask

    task automatic load_picture(input bit gaps);
        int fd0, fd_pre;
        fd0    = fd_count;
        fd_pre = fd_count;
        for (int i = 0; i < c_DEPTH; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (i == c_DEPTH - 1 && b == 2) fd_pre = fd_count;
                @(negedge clk);
                pi_flag = 1'b1;
                pi_data = pic[i][23 - 8 * b -: 8];
                if (gaps && $urandom_range(3) == 0) begin
                    @(negedge clk);
                    pi_flag = 1'b0;
                end
            end
        end
        @(negedge clk);
        pi_flag = 1'b0;
        repeat (3) @(negedge clk);
        model_valid = 1'b1;
        checks++;
        if (fd_pre !== fd0) begin
            errors++;
            $display("FAIL frame_done_early got %0d pulses exp 0", fd_pre - fd0);
        end
        checks++;
        if (fd_count - fd0 !== 1) begin
            errors++;
            $display("FAIL frame_done_count got %0d exp 1", fd_count - fd0);
        end
        checks++;
        if (pic_valid !== 1'b1) begin
            errors++;
            $display("FAIL pic_valid_after_load got %b exp 1", pic_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_valid = 1'b0;
        checks++;
        if (pix_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_pix_data got %h exp 000000", pix_data);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done got %b exp 0", frame_done);
        end
        checks++;
        if (pic_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pic_valid got %b exp 0", pic_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_bg_before_load();
        border_en = 1'b0;
        scan_frame(20, 10, 1'b0, 0);
    endtask

    task automatic test_back_to_back_ramp();
        for (int i = 0; i < c_DEPTH; i++) pic[i] = 24'(i);
        load_picture(1'b0);
        scan_frame(20, 10, 1'b0, 0);
    endtask

    task automatic test_clamp();
        scan_frame(1000, 700, 1'b1, 10);
        scan_frame(10, 700, 1'b0, 0);
    endtask

    task automatic test_border();
        border_en    = 1'b1;
        border_color = 24'hFF0000;
        scan_frame(int'($urandom_range(c_H - c_W)), int'($urandom_range(c_V - c_HT)), 1'b0, 0);
        border_en = 1'b0;
    endtask

    task automatic test_random_picture();
        for (int i = 0; i < c_DEPTH; i++) pic[i] = 24'($urandom);
        load_picture(1'b1);
        for (int f = 0; f < 2; f++) begin
            border_en    = 1'($urandom_range(1));
            border_color = 24'($urandom);
            scan_frame(int'($urandom_range(c_H + 20)), int'($urandom_range(c_V + 20)), 1'b0, 0);
        end
        border_en = 1'b0;
    endtask

    task automatic test_partial_reset();
        logic [23:0] word;
        for (int i = 0; i < 5; i++) begin
            word = 24'($urandom);
            for (int b = 0; b < 3; b++) begin
                @(negedge clk);
                pi_flag = 1'b1;
                pi_data = word[23 - 8 * b -: 8];
            end
        end
        @(negedge clk); pi_flag = 1'b1; pi_data = 8'h11;
        @(negedge clk); pi_flag = 1'b1; pi_data = 8'h22;
        @(negedge clk); pi_flag = 1'b0; rst = 1'b1;
        @(negedge clk);
        model_valid = 1'b0;
        checks++;
        if (pic_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_reset_pic_valid got %b exp 0", pic_valid);
        end
        checks++;
        if (pix_data !== 24'h0) begin
            errors++;
            $display("FAIL partial_reset_pix_data got %h exp 000000", pix_data);
        end
        rst = 1'b0;
        border_en    = 1'b1;
        border_color = 24'h00FF00;
        scan_frame(30, 20, 1'b0, 0);
        border_en = 1'b0;
        pic[0] = 24'hAABBCC;
        for (int i = 1; i < c_DEPTH; i++) pic[i] = 24'($urandom);
        load_picture(1'b0);
        scan_frame(0, 0, 1'b0, 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        fd_count    = 0;
        model_valid = 1'b0;
        test_reset();
        test_bg_before_load();
        test_back_to_back_ramp();
        test_clamp();
        test_border();
        test_random_picture();
        test_partial_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pic_win.md
Name: vga_pic_win

Overview:
Parametrised picture-in-window overlay for the HDMI/VGA path. Serial bytes (pi_data/pi_flag from the RS232 receiver) are packed into DATA_W-bit pixels and stored in an internal PIC_W x PIC_H buffer. The buffer is shown at a runtime-movable window origin with an optional border, over a constant background. Single clock domain: the writer, reader and timing counters all run on sys_clk, at one pixel per cycle.

Parameters:
H_VALID, 1024, active pixels per line
V_VALID, 768, active lines per frame
PIC_W, 200, window width in pixels
PIC_H, 200, window height in lines
DATA_W, 24, pixel width; must be a multiple of 8
ADDR_W, 16, buffer address width; 2^ADDR_W >= PIC_W*PIC_H
BORDER_W, 2, border thickness in pixels, drawn inside the window
BG_COLOR, 24'h000000, colour outside the window

Ports:
sys_clk  in  1  pixel-rate clock
sys_rst  in  1  reset; synchronous, active-high
pi_data  in  8  received byte
pi_flag  in  1  one-cycle strobe; pi_data is valid
win_x  in  12  requested window left edge
win_y  in  12  requested window top edge
border_en  in  1  enables the border
border_color  in  DATA_W  border colour
pix_x  in  12  current pixel column from the timing generator
pix_y  in  12  current pixel row from the timing generator
pix_data  out  DATA_W  output pixel colour
frame_done  out  1  one-cycle pulse when the last pixel of a picture is written
pic_valid  out  1  high once at least one full picture has been stored

Behaviour:
- Reset (sys_clk edge with sys_rst=1):
  - pix_data=0, frame_done=0, pic_valid=0.
  - Byte counter=0, wr_addr=0, rd_addr=0, latched origin wx=wy=0.
  - A partially packed pixel is discarded.
  - Buffer contents are not cleared.
- Byte packer:
  - NB=DATA_W/8.
  - On each pi_flag, shift pi_data into the pack register, first byte as MSB; byte_cnt increments.
  - On the NB-th byte, byte_cnt returns to 0 and a write strobe is issued the next cycle, writing the packed word to wr_addr.
  - pi_flag with no pending byte activity has no other effect.
  - Back-to-back pi_flag on every cycle must be sustained.
- Write address:
  - Increments after each write.
  - When the write lands on PIC_W*PIC_H-1, wr_addr wraps to 0 in the same cycle.
  - On that write, frame_done pulses high for 1 cycle and pic_valid sets. pic_valid is cleared only by reset.
- Window latch:
  - When pix_x==0 and pix_y==0, sample win_x/win_y into wx/wy.
  - Clamp: if win_x > H_VALID-PIC_W then wx=H_VALID-PIC_W; same for y with V_VALID-PIC_H.
  - The origin is otherwise constant for the whole frame; mid-frame changes to win_x/win_y are ignored.
- Window hit:
  - in_win = pix_x>=wx && pix_x<wx+PIC_W && pix_y>=wy && pix_y<wy+PIC_H.
  - Compare at 13-bit width so there is no overflow.
- Read address:
  - rd_addr clears to 0 when pix_x==0 && pix_y==0.
  - rd_addr increments by 1 on every cycle with in_win=1.
  - It therefore reaches PIC_W*PIC_H-1 at the last window pixel.
- Buffer:
  - Simple dual-port, inferred.
  - Synchronous read with 1-cycle latency.
  - Read-first on a same-cycle same-address collision: the read returns the old word.
- Output pipeline:
  - Total latency is 2 cycles from pix_x/pix_y to pix_data (RAM read plus output register).
  - in_win and the border flag are delayed to match.
- Border flag: in_win and (pix_x-wx < BORDER_W, or wx+PIC_W-1-pix_x < BORDER_W, or the same two conditions for y).
- pix_data selection, in priority order:
  1. !in_win or pix_x>=H_VALID or pix_y>=V_VALID: BG_COLOR
  2. border_en and border flag: border_color
  3. !pic_valid: BG_COLOR
  4. otherwise: the RAM word
- Border pixels still advance rd_addr, so border_en does not shift the image.
- Writing during display is permitted. Tearing is acceptable; there is no double buffering.

Test Plan:
- Reset, then 3*40000 pi_flag bytes as a 0x000000.. pixel ramp → frame_done pulses exactly once, at write 40000; pic_valid=1; wr_addr=0.
- Before any full picture, win_x=100, win_y=50, border_en=0 → pix_data=BG_COLOR everywhere, including inside the window.
- After loading the ramp, win_x=100, win_y=50 → pix_data at (100,50) = pixel 0 and at (299,249) = pixel 39999, each 2 cycles after the coordinate; (99,50) and (300,50) = BG_COLOR.
- win_x=1000, win_y=700 → clamped to wx=824, wy=568; pixel 0 appears at (824,568). Changing win_x mid-frame to 10 takes effect only from the next frame.
- border_en=1, border_color=24'hFF0000, BORDER_W=2 → columns wx, wx+1, wx+198, wx+199 and rows wy, wy+1, wy+198, wy+199 are red; (wx+2,wy+2) = pixel 2*PIC_W+2.
- Send 2 bytes, assert sys_rst for 1 cycle, then send 3 bytes AA BB CC → the first buffer word is 0xAABBCC. Bytes at 1 per cycle produce no lost writes (wr_addr advances by 1 per 3 bytes).
